// File: rtl/mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_access_unit                                                 |
// | Brief    : MAR/MDR load/store controller with byte-lane MFC handshake,     |
// |            misalignment trapping and sign/zero-extended load data.         |
// |            Optional WAIT-state timeout enabled by defining MEM_TIMEOUT_EN. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module mem_access_unit #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            Clk,
    input  logic            Clr,
    input  logic            start,
    input  logic            rw,
    input  logic [1:0]      size,
    input  logic            sign_ext,
    input  logic [AW-1:0]   addr,
    input  logic [DW-1:0]   wdata,
    output logic [DW-1:0]   rdata,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            mem_en,
    output logic            mem_rw,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_mfc
);
    localparam int NB = DW / 8;
    localparam int LW = $clog2(NB);
    localparam logic DWORD_OK = (DW == 64);
    localparam logic [NB-1:0] c_BE_BYTE = 1;
    localparam logic [NB-1:0] c_BE_HALF = 3;
    localparam logic [NB-1:0] c_BE_WORD = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    if ((DW != 32 && DW != 64) || TIMEOUT < 1) begin : g_badParams
        $error("mem_access_unit: DW must be 32 or 64 and TIMEOUT at least 1");
    end

    state_t          r_state;
    logic            r_rw;
    logic            r_signExt;
    logic [1:0]      r_size;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;

    logic [LW-1:0]   w_lane;
    logic            w_fault;
    logic [NB-1:0]   w_beBase;
    logic [DW-1:0]   w_wdataRep;
    logic [DW-1:0]   w_laneData;
    logic [DW-1:0]   w_loadData;
    logic            w_msb;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] c_TO_LAST = CW'(TIMEOUT - 1);
    logic [CW-1:0]   r_waitCnt;
`endif

    assign w_lane = r_addr[LW-1:0];

    always_comb begin
        w_fault  = 1'b0;
        w_beBase = '1;
        case (r_size)
            2'b00: begin
                w_fault  = 1'b0;
                w_beBase = c_BE_BYTE;
            end
            2'b01: begin
                w_fault  = r_addr[0];
                w_beBase = c_BE_HALF;
            end
            2'b10: begin
                w_fault  = |r_addr[1:0];
                w_beBase = c_BE_WORD;
            end
            default: begin
                w_fault  = !DWORD_OK || (|r_addr[2:0]);
                w_beBase = '1;
            end
        endcase
    end

    // Store data is replicated so every lane of the access size carries it.
    always_comb begin
        w_wdataRep = '0;
        for (int i = 0; i < NB; i++) begin
            case (r_size)
                2'b00:   w_wdataRep[i*8 +: 8] = r_wdata[7:0];
                2'b01:   w_wdataRep[i*8 +: 8] = r_wdata[(i%2)*8 +: 8];
                2'b10:   w_wdataRep[i*8 +: 8] = r_wdata[(i%4)*8 +: 8];
                default: w_wdataRep[i*8 +: 8] = r_wdata[i*8 +: 8];
            endcase
        end
    end

    always_comb begin
        w_laneData = mem_rdata >> {w_lane, 3'b000};
        case (r_size)
            2'b00:   w_msb = w_laneData[7];
            2'b01:   w_msb = w_laneData[15];
            2'b10:   w_msb = w_laneData[31];
            default: w_msb = w_laneData[DW-1];
        endcase
        w_loadData = '0;
        for (int i = 0; i < DW; i++) begin
            w_loadData[i] = (i < (8 << r_size)) ? w_laneData[i] : (w_msb & r_signExt);
        end
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            r_state   <= IDLE;
            r_rw      <= 1'b0;
            r_signExt <= 1'b0;
            r_size    <= 2'b00;
            r_addr    <= '0;
            r_wdata   <= '0;
            rdata     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_en    <= 1'b0;
            mem_rw    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
`ifdef MEM_TIMEOUT_EN
            r_waitCnt <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_rw      <= rw;
                        r_size    <= size;
                        r_signExt <= sign_ext;
                        r_addr    <= addr;
                        r_wdata   <= wdata;
                        mem_rw    <= rw;
                        busy      <= 1'b1;
                        r_state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (w_fault) begin
                        done    <= 1'b1;
                        err     <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        mem_addr  <= {r_addr[AW-1:LW], {LW{1'b0}}};
                        mem_be    <= w_beBase << w_lane;
                        mem_wdata <= w_wdataRep;
                        mem_en    <= 1'b1;
                        r_state   <= WAIT;
`ifdef MEM_TIMEOUT_EN
                        r_waitCnt <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (mem_mfc) begin
                        mem_en  <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                        if (!r_rw) begin
                            rdata <= w_loadData;
                        end
`ifdef MEM_TIMEOUT_EN
                    end else if (r_waitCnt == c_TO_LAST) begin
                        mem_en  <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_waitCnt <= r_waitCnt + 1'b1;
`endif
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    err     <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire
